// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter for NUM_REQ AXI-Stream requesters.
// There is one output register stage, and the winning index is stamped into tid.
//
// state | meaning
// IDLE  | between packets; round-robin pick from rr_ptr every cycle
// LOCK  | mid-packet; grant held on one requester until its tlast beat
module axis_packet_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int TDATA_WIDTH   = 512,
    parameter int TDEST_WIDTH   = 4,
    parameter int TID_WIDTH     = 2,
    parameter int MAX_PKT_BEATS = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    s_axis_tvalid,
    output logic [NUM_REQ-1:0]                    s_axis_tready,
    input  logic [NUM_REQ-1:0][TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_REQ-1:0]                    s_axis_tlast,
    input  logic [NUM_REQ-1:0][TDEST_WIDTH-1:0]   s_axis_tdest,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [TDATA_WIDTH-1:0]                m_axis_tdata,
    output logic                                  m_axis_tlast,
    output logic [TID_WIDTH-1:0]                  m_axis_tid,
    output logic [TDEST_WIDTH-1:0]                m_axis_tdest,
    output logic                                  lock_active,
    output logic [TID_WIDTH-1:0]                  lock_id,
    output logic                                  err_oversize
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_PKT_BEATS + 2);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] grant, grant_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_nxt;
    logic [PTR_W-1:0] rr_sel, sel, idx;
    logic             rr_hit, any_valid, load_en, accept;

    assign any_valid = |s_axis_tvalid;
    assign load_en   = !m_axis_tvalid || m_axis_tready;

    always_comb begin
        rr_sel = rr_ptr;
        rr_hit = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!rr_hit && s_axis_tvalid[idx]) begin
                rr_hit = 1'b1;
                rr_sel = idx;
            end
        end
    end

    assign sel    = (state == LOCK) ? grant : rr_sel;
    assign accept = load_en && s_axis_tvalid[sel] && (state == LOCK || any_valid);

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_axis_tready[i] = load_en && (PTR_W'(i) == sel) && (state == LOCK || any_valid);
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        cnt_nxt   = cnt;
        err_nxt   = err_oversize;
        if (accept) begin
            if (MAX_PKT_BEATS > 0 && cnt == CNT_W'(MAX_PKT_BEATS)) begin
                err_nxt = 1'b1;
            end
            if (s_axis_tlast[sel]) begin
                state_nxt = IDLE;
                rr_nxt    = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                cnt_nxt   = '0;
            end else begin
                state_nxt = LOCK;
                grant_nxt = sel;
                if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            cnt          <= '0;
            err_oversize <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            rr_ptr       <= rr_nxt;
            cnt          <= cnt_nxt;
            err_oversize <= err_nxt;
        end
    end

    // Output stage reloads whenever it is empty or draining; otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
        end else if (load_en) begin
            m_axis_tvalid <= accept;
            if (accept) begin
                m_axis_tdata <= s_axis_tdata[sel];
                m_axis_tlast <= s_axis_tlast[sel];
                m_axis_tid   <= TID_WIDTH'(sel);
                m_axis_tdest <= s_axis_tdest[sel];
            end
        end
    end

    assign lock_active = (state == LOCK);
    assign lock_id     = TID_WIDTH'(grant);

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-atomic round-robin arbiter that lets NUM_REQ AXI-Stream requesters share one injection port of a mesh node. Grant is held from a packet's first beat through its tlast beat, so flits of different packets never interleave. The block stamps the winning requester index into tid for demux at the destination. A single output register stage sits between the arbiter and the mesh's `axis_in_*` port, in the user clock domain.

## Interface

**Parameters**
- NUM_REQ, 4: number of requesters; must be ≥1.
- TDATA_WIDTH, 512: payload width.
- TDEST_WIDTH, 4: destination width, passed through unchanged.
- TID_WIDTH, 2: tid width; must be ≥ max(1, clog2(NUM_REQ)).
- MAX_PKT_BEATS, 0: oversize check limit; 0 disables the check.

**Ports**
- clk, input, 1: sole clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- s_axis_tvalid, input, 1 × [NUM_REQ]: requester valid.
- s_axis_tready, output, 1 × [NUM_REQ]: requester ready.
- s_axis_tdata, input, TDATA_WIDTH × [NUM_REQ]: requester payload.
- s_axis_tlast, input, 1 × [NUM_REQ]: last beat of packet.
- s_axis_tdest, input, TDEST_WIDTH × [NUM_REQ]: destination.
- m_axis_tvalid, output, 1: output valid.
- m_axis_tready, input, 1: output ready.
- m_axis_tdata, output, TDATA_WIDTH: payload.
- m_axis_tlast, output, 1: last beat of packet.
- m_axis_tid, output, TID_WIDTH: source requester index, zero-extended.
- m_axis_tdest, output, TDEST_WIDTH: destination.
- lock_active, output, 1: high while a packet is mid-transfer (state LOCK).
- lock_id, output, TID_WIDTH: requester currently holding the lock.
- err_oversize, output, 1: sticky; a packet exceeded MAX_PKT_BEATS.

## Operation

**Internal state**
- FSM: `state` ∈ {IDLE, LOCK}.
- `grant` register, holds the locked requester.
- `rr_ptr` round-robin pointer, range 0..NUM_REQ-1.
- Beat counter, width clog2(MAX_PKT_BEATS+2).
- Output register.

**Selection**
- `load_en` = !m_axis_tvalid || m_axis_tready.
- IDLE: `sel` = first i with s_axis_tvalid[i] = 1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- LOCK: `sel` = `grant`. All other requesters' tvalid are ignored.
- s_axis_tready[i] = load_en && i == sel && (state == LOCK || any tvalid). All other readies are 0.

**Beat accept** (s_axis_tvalid[sel] && s_axis_tready[sel])
- Output register loads tdata, tlast, and tdest of `sel`; tid = sel.
- If tlast:
  - state → IDLE.
  - rr_ptr → (sel+1) mod NUM_REQ.
  - Beat counter → 0.
- If not tlast:
  - state → LOCK.
  - grant → sel.
  - Beat counter increments, saturating.

**Output register**
- If load_en and no beat is accepted, m_axis_tvalid → 0.
- If m_axis_tvalid && !m_axis_tready, all m_* hold stable.

**LOCK with locked requester's tvalid low**
- Grant is held indefinitely and bubbles are emitted. There is no timeout and no preemption.

**Oversize check**
- Applies when MAX_PKT_BEATS > 0.
- Accepting beat number MAX_PKT_BEATS+1 of a packet (count before the beat = MAX_PKT_BEATS) sets err_oversize.
- err_oversize stays set until reset. The packet is still forwarded intact.

**NUM_REQ = 1**
- rr_ptr is constant 0 and tid is always 0.

**Status outputs**
- lock_active = (state == LOCK).
- lock_id = grant.

## Timing

**Reset values** (asserted asynchronously when rst_n falls)
- m_axis_tvalid = 0; m_axis_tdata, tlast, tid, tdest = 0.
- state = IDLE, grant = 0, rr_ptr = 0, beat count = 0.
- lock_active = 0, lock_id = 0, err_oversize = 0.
- s_axis_tready follows the combinational rule, with load_en = 1.

**Latency and throughput**
- A beat accepted at edge N appears on m_* after edge N, i.e. 1 cycle latency.
- Sustained 1 beat/cycle, including across packet boundaries and requester switches. No arbitration bubble.

**Timing of the arbitration decision**
- The IDLE choice is combinational in the same cycle as the first-beat accept. Grant changes take effect only at a tlast accept.

**Reset mid-packet**
- The packet is truncated with no tlast emitted. Upstream handles recovery.
- After release, arbitration restarts from rr_ptr = 0.

## Test plan

1. **Single packet.** Req0 sends a 3-beat packet (D0..D2), m_tready=1.
   - m_* shows D0, D1, D2 on consecutive cycles, one cycle after each accept.
   - tid=0, tlast only with D2, lock_active high after D0 and D1.
2. **Round-robin with single-beat packets.** All 4 requesters continuously offer 1-beat packets, m_tready=1.
   - Output tid sequence is 0,1,2,3,0,1…, one beat per cycle, no bubbles.
3. **Packet atomicity.** Req1 sends a 4-beat packet with tvalid low for 2 cycles after beat 2; req2 is valid throughout.
   - s_axis_tready[2] stays 0 until req1's tlast is accepted.
   - Output shows 4 req1 beats with a 2-cycle gap, then req2's beat; no interleave.
4. **Backpressure.** Output full; hold m_tready=0 for 3 cycles.
   - m_* stable and all s_axis_tready=0 during the stall.
   - Stream resumes with no beat lost or duplicated.
5. **Oversize detection.** MAX_PKT_BEATS=4; req3 sends a 6-beat packet.
   - err_oversize rises the cycle after the 5th beat accept and stays high.
   - All 6 beats are forwarded with tid=3.
6. **Reset mid-packet.** Pull rst_n low during beat 2 of a req2 packet.
   - m_axis_tvalid drops immediately.
   - After release, req2 and req0 both valid: req0 wins (rr_ptr=0).
